result_port_writer: RTL and testbench
=====================================

# result_port_writer

Transmit side of the test-port result protocol: drives begin-symbol, result words and end-symbol as discrete writes to the memory-mapped test port. Results arrive from the core-side result source over a valid/ready handshake and are buffered in a small FIFO. Each word is emitted as a single write pulse on the data-memory write interface, honoring the D-cache stall. The output stream is exactly what the pass/fail checker expects: one write per wen assertion, separated by at least one wen-low cycle, data in little-endian byte order.

## Interface
- TEST_PORT, 30'hFF, word address of the test port
- BEGIN_SYMBOL, 32'h00000168, first word of every session
- END_SYMBOL, 32'hFFFFFD5D, last word of every session
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- MAX_RESULTS, 32, result count that implicitly closes the session
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse: open a session (honored in IDLE or DONE only)
- res_valid  in  1  result word offered
- res_data  in  32  result word, readable byte order
- res_last  in  1  qualifies res_data as final result
- res_ready  out  1  FIFO accepts this cycle
- mem_wen  out  1  write strobe to data memory
- mem_addr  out  30  TEST_PORT while mem_wen, else 0
- mem_wdata  out  32  byte-swapped word while mem_wen, else 0
- mem_stall  in  1  memory not accepting; hold current write
- busy  out  1  session in progress
- done  out  1  END_SYMBOL written, held until start or rst
- sent_count  out  7  result words written this session (excludes begin/end)

## Operation
- States: IDLE, WR_BEGIN, GAP, WR_DATA, WR_END, DONE. Moore outputs decoded from registered state plus FIFO head.
- IDLE: start -> WR_BEGIN; clear FIFO, last_seen, accepted count, sent_count.
- WR_BEGIN/WR_DATA/WR_END: mem_wen=1, mem_addr=TEST_PORT, mem_wdata = {w[7:0],w[15:8],w[23:16],w[31:24]} of BEGIN_SYMBOL / FIFO head / END_SYMBOL. Stay while mem_stall=1 (outputs stable). Cycle with mem_stall=0 completes the write -> GAP; WR_DATA completion pops FIFO and increments sent_count; WR_END completion sets end_sent.
- GAP: mem_wen=0 for ≥1 cycle. Next: end_sent -> DONE; FIFO non-empty -> WR_DATA; FIFO empty and last_seen -> WR_END; else remain in GAP.
- DONE: done=1, busy=0; start -> WR_BEGIN (new session, done cleared).
- busy=1 in WR_BEGIN, GAP, WR_DATA, WR_END.
- res_ready = busy & !last_seen & !full (registered-state function, no combinational path from res_valid).
- Push on res_valid & res_ready. res_last on a push, or accepted count reaching MAX_RESULTS, sets last_seen; further res_ready=0.
- Push and pop in same cycle allowed when not full; count unchanged.
- FIFO pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
- start while busy ignored. res_valid outside a session ignored (res_ready=0).

## Timing
- Reset values: state IDLE, mem_wen 0, mem_addr 0, mem_wdata 0, res_ready 0, busy 0, done 0, sent_count 0, FIFO empty.
- rst asserted mid-write drops mem_wen immediately (async); pending FIFO data discarded.
- start at edge t -> mem_wen=1 with begin word from cycle t+1.
- Unstalled write: mem_wen high exactly 1 cycle, then ≥1 low cycle; minimum 2 cycles per word.
- Result pushed at edge t into empty FIFO while in GAP -> WR_DATA from cycle t+1.
- Stall of N cycles extends the write to N+1 cycles; exactly one pop per word.
- done rises the cycle after END_SYMBOL write completes (after its GAP).

## Test plan
- Basic: start, push 0,1,1 (last on third), no stall -> writes 0x68010000, 0x00000000, 0x01000000, 0x01000000, 0x5DFDFFFF at TEST_PORT, each wen 1 cycle with low gap; done=1, sent_count=3.
- Stall: mem_stall high 3 cycles at first WR_DATA (value 5) -> wen high 4 cycles, mem_wdata=0x05000000 stable, one pop, sent_count=1 after.
- Backpressure: stall held, push 6 words with DEPTH=4 -> res_ready low once 4 buffered; release stall -> all 6 written in push order, none lost or duplicated.
- Implicit close: push 32 words, res_last never set -> res_ready low after 32nd accept; END written after 32nd data write; sent_count=32.
- Reset mid-op: rst during stalled WR_DATA with 3 buffered -> mem_wen 0 same cycle, all outputs at reset values; subsequent start produces fresh begin word, sent_count restarts at 0.
- Start handling: start pulses while busy ignored (single begin word); start in DONE -> new begin write, done falls.

Source files
------------

// File: rtl/result_port_writer_if.sv
// Result-source handshake and data-memory write bus seen by result_port_writer.
// The writer takes the master side of the memory bus and the sink side of the result handshake.
interface result_port_writer_if;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_last;
  logic        res_ready;
  logic        mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;

  modport master (
    input  res_valid, res_data, res_last, mem_stall,
    output res_ready, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output res_valid, res_data, res_last, mem_stall,
    input  res_ready, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/result_port_writer.sv
// Test-port transmitter: begin symbol, buffered result words, end symbol, each written
// as one strobe to the data memory with a mandatory low cycle between strobes.
module result_port_writer #(
  parameter logic [29:0] TEST_PORT    = 30'hFF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          DEPTH        = 4,
  parameter int          MAX_RESULTS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  result_port_writer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           sent_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_BEGIN = 3'd1;
  localparam logic [2:0] S_GAP      = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_END   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state, state_nx;
  logic [31:0]   fifo [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [6:0]    acc_cnt;
  logic          last_seen, end_sent;
  logic          full, empty, push, pop, wr_done, open;
  logic [31:0]   word;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state == S_WR_BEGIN) || (state == S_GAP) ||
                   (state == S_WR_DATA)  || (state == S_WR_END);
  assign done    = (state == S_DONE);
  assign open    = start && ((state == S_IDLE) || (state == S_DONE));

  // Ready depends only on registered state, so no path from res_valid to res_ready.
  assign bus.res_ready = busy && !last_seen && !full;
  assign push          = bus.res_valid && bus.res_ready;

  assign bus.mem_wen = (state == S_WR_BEGIN) || (state == S_WR_DATA) || (state == S_WR_END);
  assign wr_done     = bus.mem_wen && !bus.mem_stall;
  assign pop         = (state == S_WR_DATA) && wr_done;

  always_comb begin
    word = '0;
    case (state)
      S_WR_BEGIN: word = BEGIN_SYMBOL;
      S_WR_DATA:  word = fifo[rd_ptr];
      S_WR_END:   word = END_SYMBOL;
      default:    word = '0;
    endcase
  end

  // Checker reads the port little-endian, so the readable word goes out byte-reversed.
  assign bus.mem_addr  = bus.mem_wen ? TEST_PORT : '0;
  assign bus.mem_wdata = {word[7:0], word[15:8], word[23:16], word[31:24]};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_WR_BEGIN;
      S_WR_BEGIN, S_WR_DATA, S_WR_END: if (!bus.mem_stall) state_nx = S_GAP;
      S_GAP: begin
        if (end_sent)       state_nx = S_DONE;
        else if (!empty)    state_nx = S_WR_DATA;
        else if (last_seen) state_nx = S_WR_END;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc_cnt    <= '0;
      last_seen  <= 1'b0;
      end_sent   <= 1'b0;
      sent_count <= '0;
    end else begin
      state <= state_nx;
      if (open) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        acc_cnt    <= '0;
        last_seen  <= 1'b0;
        end_sent   <= 1'b0;
        sent_count <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          acc_cnt <= acc_cnt + 7'd1;
          if (bus.res_last || (acc_cnt + 7'd1 == 7'(MAX_RESULTS))) last_seen <= 1'b1;
        end
        if (pop) begin
          rd_ptr     <= rd_ptr + 1'b1;
          sent_count <= sent_count + 7'd1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if ((state == S_WR_END) && wr_done) end_sent <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.res_data;
  end

endmodule

// File: tb/tb_result_port_writer.sv
// Randomized bench for result_port_writer: a queue model of the expected test-port
// stream (begin, accepted words byte-reversed, end) plus per-cycle protocol monitors.
module tb_result_port_writer;
  localparam int          DEPTH = 4;
  localparam int          MAXR  = 32;
  localparam logic [29:0] TP    = 30'hFF;
  localparam logic [31:0] BEG   = 32'h00000168;
  localparam logic [31:0] ENDS  = 32'hFFFFFD5D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [6:0] sent_count;

  result_port_writer_if bus();

  result_port_writer #(.DEPTH(DEPTH), .MAX_RESULTS(MAXR)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic l; } src_t;
  src_t        src_q[$];
  logic [31:0] words[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];

  int total = 0, bad = 0;
  int acc_n, lim, wen_cyc, stall_cyc, gap_err, addr_err, ready_err;
  int stall_pct = 0, valid_pct = 100;
  bit prev_cmp = 1'b0;
  logic        first_wen, first_done;
  logic [31:0] first_data;
  logic [6:0]  first_sent;

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {<<8{w}};
  endfunction

  // -1 when the captured stream equals the model, else first differing index.
  function automatic int stream_diff();
    if (wr_q.size() != exp_q.size()) return (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    foreach (wr_q[i]) if (wr_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Monitor: source acceptance, ready legality, completed writes, gap and address rules.
  always @(negedge clk) begin : mon
    int buffered;
    if (rst) begin
      prev_cmp = 1'b0;
    end else begin
      buffered = acc_n - ((wr_q.size() > 0) ? wr_q.size() - 1 : 0);
      if (bus.res_ready && (acc_n >= lim || buffered >= DEPTH)) ready_err++;
      if (bus.res_valid && bus.res_ready) begin
        acc_n++;
        if (src_q.size() > 0) src_q.delete(0);
      end
      if (bus.mem_wen) begin
        wen_cyc++;
        if (bus.mem_addr !== TP) addr_err++;
        if (prev_cmp) gap_err++;
        if (bus.mem_stall) stall_cyc++;
        else wr_q.push_back(bus.mem_wdata);
      end else if (bus.mem_addr !== 30'd0 || bus.mem_wdata !== 32'd0) begin
        addr_err++;
      end
      prev_cmp = bus.mem_wen && !bus.mem_stall;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (stall_pct > 0) bus.mem_stall = ($urandom_range(0, 99) < stall_pct);
    if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      bus.res_valid = 1'b1;
      bus.res_data  = src_q[0].d;
      bus.res_last  = src_q[0].l;
    end else begin
      bus.res_valid = 1'b0;
      bus.res_data  = $urandom;
      bus.res_last  = 1'b0;
    end
  endtask

  // Loads words[] as the source and builds the expected stream from the session rules.
  task automatic setup(input bit with_last);
    int k;
    src_q.delete(); exp_q.delete(); wr_q.delete();
    acc_n = 0; wen_cyc = 0; stall_cyc = 0; gap_err = 0; addr_err = 0; ready_err = 0;
    k = (with_last && words.size() < MAXR) ? words.size() : MAXR;
    lim = k;
    exp_q.push_back(swap(BEG));
    foreach (words[i]) begin
      src_q.push_back('{words[i], with_last && (i == words.size() - 1)});
      if (i < k) exp_q.push_back(swap(words[i]));
    end
    exp_q.push_back(swap(ENDS));
  endtask

  task automatic run(input int budget, input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    first_wen = bus.mem_wen; first_data = bus.mem_wdata;
    first_done = done; first_sent = sent_count;
    for (int c = 0; c < budget && !done; c++) begin
      start = poke && (c % 3 == 0);
      step();
      start = 1'b0;
    end
    total++;
    if (!done) begin bad++; $display("FAIL session_timeout: done=%0b after %0d cycles, want 1", done, budget); end
    src_q.delete();
    bus.res_valid = 1'b0;
    if (stall_pct > 0) begin stall_pct = 0; bus.mem_stall = 1'b0; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata} !== 63'd0) begin
      bad++; $display("FAIL reset_bus: wen=%0b addr=%0h wdata=%0h, want all 0", bus.mem_wen, bus.mem_addr, bus.mem_wdata);
    end
    total++;
    if ({bus.res_ready, busy, done, sent_count} !== 10'd0) begin
      bad++; $display("FAIL reset_status: ready=%0b busy=%0b done=%0b sent=%0d, want 0", bus.res_ready, busy, done, sent_count);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.res_ready !== 1'b0 || bus.mem_wen !== 1'b0) begin
      bad++; $display("FAIL idle_quiet: ready=%0b wen=%0b, want 0 0", bus.res_ready, bus.mem_wen);
    end
  endtask

  task automatic test_basic();
    logic [31:0] lit[5];
    int d;
    lit = '{32'h68010000, 32'h00000000, 32'h01000000, 32'h01000000, 32'h5DFDFFFF};
    words = '{32'd0, 32'd1, 32'd1};
    setup(1'b1);
    run(100, 1'b0);
    total++;
    if (first_wen !== 1'b1 || first_data !== 32'h68010000) begin
      bad++; $display("FAIL basic_first: wen=%0b data=%08h, want 1 68010000", first_wen, first_data);
    end
    d = -1;
    if (wr_q.size() != 5) d = 99;
    else foreach (lit[i]) if (d < 0 && wr_q[i] !== lit[i]) d = i;
    total++;
    if (d >= 0) begin bad++; $display("FAIL basic_stream: %0d writes, bad at %0d, want 5 literal words", wr_q.size(), d); end
    total++;
    if (done !== 1'b1 || sent_count !== 7'd3) begin
      bad++; $display("FAIL basic_status: done=%0b sent=%0d, want 1 3", done, sent_count);
    end
    total++;
    if (wen_cyc != 5 || gap_err != 0 || addr_err != 0) begin
      bad++; $display("FAIL basic_pulses: wen_cycles=%0d gap_err=%0d addr_err=%0d, want 5 0 0", wen_cyc, gap_err, addr_err);
    end
  endtask

  task automatic test_stall();
    int d;
    words = '{32'd5};
    setup(1'b1);
    bus.mem_stall = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    bus.mem_stall = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.mem_wen !== 1'b1 || bus.mem_wdata !== 32'h05000000 || sent_count !== 7'd0) begin
        bad++; $display("FAIL stall_hold%0d: wen=%0b data=%08h sent=%0d, want 1 05000000 0", i, bus.mem_wen, bus.mem_wdata, sent_count);
      end
      if (i == 3) bus.mem_stall = 1'b0;
      step();
    end
    total++;
    if (bus.mem_wen !== 1'b0 || sent_count !== 7'd1) begin
      bad++; $display("FAIL stall_after: wen=%0b sent=%0d, want 0 1", bus.mem_wen, sent_count);
    end
    for (int c = 0; c < 50 && !done; c++) step();
    d = stream_diff();
    total++;
    if (d >= 0 || stall_cyc != 3 || wen_cyc != 6) begin
      bad++; $display("FAIL stall_stream: diff_at=%0d stall_cyc=%0d wen_cyc=%0d, want -1 3 6", d, stall_cyc, wen_cyc);
    end
  endtask

  task automatic test_backpressure();
    int d;
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back($urandom);
    setup(1'b1);
    bus.mem_stall = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    total++;
    if (acc_n != DEPTH || bus.res_ready !== 1'b0 || wr_q.size() != 0) begin
      bad++; $display("FAIL bp_full: accepted=%0d ready=%0b writes=%0d, want %0d 0 0", acc_n, bus.res_ready, wr_q.size(), DEPTH);
    end
    bus.mem_stall = 1'b0;
    for (int c = 0; c < 100 && !done; c++) step();
    d = stream_diff();
    total++;
    if (d >= 0 || sent_count !== 7'd6 || ready_err != 0) begin
      bad++; $display("FAIL bp_stream: diff_at=%0d sent=%0d ready_err=%0d, want -1 6 0", d, sent_count, ready_err);
    end
  endtask

  task automatic test_implicit_close();
    int d;
    words.delete();
    for (int i = 0; i < MAXR + 1; i++) words.push_back($urandom);
    setup(1'b0);
    run(400, 1'b0);
    d = stream_diff();
    total++;
    if (acc_n != MAXR || ready_err != 0) begin
      bad++; $display("FAIL implicit_accept: accepted=%0d ready_err=%0d, want %0d 0", acc_n, ready_err, MAXR);
    end
    total++;
    if (d >= 0 || sent_count !== 7'(MAXR)) begin
      bad++; $display("FAIL implicit_stream: diff_at=%0d sent=%0d, want -1 %0d", d, sent_count, MAXR);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic [31:0] w0;
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    w0 = words[0];
    setup(1'b0);
    bus.mem_stall = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    bus.mem_stall = 1'b0;
    step();
    bus.mem_stall = 1'b1;
    step();
    total++;
    if (acc_n != 3 || bus.mem_wen !== 1'b1 || bus.mem_wdata !== swap(w0)) begin
      bad++; $display("FAIL rmid_setup: accepted=%0d wen=%0b data=%08h, want 3 1 %08h", acc_n, bus.mem_wen, bus.mem_wdata, swap(w0));
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.res_ready, busy, done, sent_count} !== 73'd0) begin
      bad++; $display("FAIL rmid_async: wen=%0b addr=%0h data=%0h ready=%0b busy=%0b done=%0b sent=%0d, want all 0",
                      bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.res_ready, busy, done, sent_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_stall = 1'b0;
    step();
    words = '{$urandom};
    setup(1'b1);
    run(100, 1'b0);
    d = stream_diff();
    total++;
    if (first_data !== swap(BEG) || first_sent !== 7'd0) begin
      bad++; $display("FAIL rmid_fresh: data=%08h sent=%0d, want %08h 0", first_data, first_sent, swap(BEG));
    end
    total++;
    if (d >= 0 || sent_count !== 7'd1) begin
      bad++; $display("FAIL rmid_stream: diff_at=%0d sent=%0d, want -1 1", d, sent_count);
    end
  endtask

  task automatic test_start_handling();
    int d;
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    setup(1'b1);
    stall_pct = 20;
    run(200, 1'b1);
    d = stream_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL start_busy: diff_at=%0d writes=%0d, want -1 %0d", d, wr_q.size(), exp_q.size()); end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL start_done_hold: done=%0b busy=%0b, want 1 0", done, busy);
    end
    words = '{$urandom, $urandom};
    setup(1'b1);
    run(100, 1'b0);
    d = stream_diff();
    total++;
    if (first_done !== 1'b0 || first_wen !== 1'b1 || first_data !== swap(BEG)) begin
      bad++; $display("FAIL start_restart: done=%0b wen=%0b data=%08h, want 0 1 %08h", first_done, first_wen, first_data, swap(BEG));
    end
    total++;
    if (d >= 0 || sent_count !== 7'd2) begin
      bad++; $display("FAIL start_stream2: diff_at=%0d sent=%0d, want -1 2", d, sent_count);
    end
  endtask

  task automatic test_random();
    int d, n;
    for (int s = 0; s < 3; s++) begin
      n = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      setup(1'b1);
      stall_pct = 30;
      valid_pct = 60;
      run(400, 1'b0);
      valid_pct = 100;
      d = stream_diff();
      total++;
      if (d >= 0 || sent_count !== 7'(n)) begin
        bad++; $display("FAIL rand%0d_stream: diff_at=%0d sent=%0d, want -1 %0d", s, d, sent_count, n);
      end
      total++;
      if (gap_err != 0 || addr_err != 0 || ready_err != 0 || wen_cyc != wr_q.size() + stall_cyc) begin
        bad++; $display("FAIL rand%0d_proto: gap=%0d addr=%0d ready=%0d wen_cyc=%0d writes+stalls=%0d, want 0 0 0 equal",
                        s, gap_err, addr_err, ready_err, wen_cyc, wr_q.size() + stall_cyc);
      end
    end
  endtask

  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_last  = 1'b0;
    bus.mem_stall = 1'b0;
    lim = MAXR; acc_n = 0;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_implicit_close();
    test_reset_mid();
    test_start_handling();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
